// File: rtl/uriscv_defs.sv
// rtl/uriscv_defs.sv - RV_ALU_* op encodings shared by the ALU and its users
//
// Purpose: single source of the 4-bit ALU operation encodings.
// Ports:   none (package of localparams).
package uriscv_defs;

  localparam logic [3:0] RV_ALU_NONE             = 4'b0000;
  localparam logic [3:0] RV_ALU_SHIFTL           = 4'b0001;
  localparam logic [3:0] RV_ALU_SHIFTR           = 4'b0010;
  localparam logic [3:0] RV_ALU_SHIFTR_ARITH     = 4'b0011;
  localparam logic [3:0] RV_ALU_ADD              = 4'b0100;
  localparam logic [3:0] RV_ALU_SUB              = 4'b0110;
  localparam logic [3:0] RV_ALU_AND              = 4'b0111;
  localparam logic [3:0] RV_ALU_OR               = 4'b1000;
  localparam logic [3:0] RV_ALU_XOR              = 4'b1001;
  localparam logic [3:0] RV_ALU_LESS_THAN        = 4'b1010;
  localparam logic [3:0] RV_ALU_LESS_THAN_SIGNED = 4'b1011;

endpackage

// File: rtl/uriscv_pkg.sv
// rtl/uriscv_pkg.sv - shared types for the ALU arbiter
//
// Purpose: requester id enum, the request bundle used by the port mux,
//          and the idle request driven into the ALU when nothing is granted.
// Ports:   none (package).
package uriscv_pkg;

  import uriscv_defs::RV_ALU_ADD;

  // Widest caller tag the shared request bundle can carry; the arbiter's
  // TAG_W parameter must not exceed this.
  localparam int ALU_TAG_MAX_W = 16;

  typedef enum logic {
    REQ_PIPE = 1'b0,
    REQ_AUX  = 1'b1
  } alu_req_id_t;

  typedef struct packed {
    logic [3:0]               op;
    logic [31:0]              a;
    logic [31:0]              b;
    logic [ALU_TAG_MAX_W-1:0] tag;
  } alu_req_t;

  // ADD of zeros keeps the ALU inputs defined while no port is granted.
  function automatic alu_req_t alu_req_idle();
    alu_req_t r;
    r     = '0;
    r.op  = RV_ALU_ADD;
    return r;
  endfunction

endpackage

// File: rtl/uriscv_alu.sv
// rtl/uriscv_alu.sv - single-cycle combinational RISC-V integer ALU
//
// Purpose: computes one RV_ALU_* operation on two 32-bit operands.
// Ports:
//   i_op     in  4   RV_ALU_* operation
//   i_a      in  32  operand a
//   i_b      in  32  operand b (shift amount in bits [4:0] for shifts)
//   o_result out 32  result
module uriscv_alu
  import uriscv_defs::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  logic signed [31:0] w_sra;
  logic               w_lt;
  logic               w_lts;

  assign w_sra = $signed(i_a) >>> i_b[4:0];
  assign w_lt  = (i_a < i_b);
  assign w_lts = ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_result = i_a;
    case (i_op)
      RV_ALU_NONE:             o_result = i_a;
      RV_ALU_SHIFTL:           o_result = i_a << i_b[4:0];
      RV_ALU_SHIFTR:           o_result = i_a >> i_b[4:0];
      RV_ALU_SHIFTR_ARITH:     o_result = w_sra;
      RV_ALU_ADD:              o_result = i_a + i_b;
      RV_ALU_SUB:              o_result = i_a - i_b;
      RV_ALU_AND:              o_result = i_a & i_b;
      RV_ALU_OR:               o_result = i_a | i_b;
      RV_ALU_XOR:              o_result = i_a ^ i_b;
      RV_ALU_LESS_THAN:        o_result = {31'b0, w_lt};
      RV_ALU_LESS_THAN_SIGNED: o_result = {31'b0, w_lts};
      default:                 o_result = i_a;
    endcase
  end

endmodule

// File: rtl/uriscv_rr_arb2.sv
// rtl/uriscv_rr_arb2.sv - two-way arbiter, round-robin or fixed priority
//
// Purpose: one-hot grant between two requesters. With URISCV_ALU_ARB_RR_EN
//          defined, conflicts go to the port that did not win the last
//          accepted transfer; otherwise port 0 always wins conflicts.
// Macro:   URISCV_ALU_ARB_RR_EN
// Ports:
//   i_clk    in  1  clock
//   i_rst    in  1  synchronous active-high reset
//   i_valid  in  2  per-port request valid
//   i_accept in  1  the current grant was accepted this cycle
//   o_grant  out 2  one-hot grant (zero when no port is valid)
module uriscv_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

`ifdef URISCV_ALU_ARB_RR_EN
  // Port that won the most recent accepted transfer. Resets to 1 so that
  // port 0 wins the first conflict. A stalled grant never moves it.
  logic r_last_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant[1];
    end
  end

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end
`else
  // Fixed priority keeps no state; clock, reset and accept are unneeded.
  logic w_unused_fixed;
  assign w_unused_fixed = ^{i_clk, i_rst, i_accept};

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/uriscv_alu_arb.sv
// rtl/uriscv_alu_arb.sv - shares one uriscv_alu between two requesters
//
// Purpose: arbitrates port 0 (execute stage) and port 1 (address/CSR
//          helper) onto one ALU; each accepted op lands one cycle later in
//          a single response register tagged with requester id and tag.
// Macro:   URISCV_ALU_ARB_RR_EN selects round-robin conflict resolution
//          (default: port 0 fixed priority).
// Parameters:
//   TAG_W  caller tag width, 1..ALU_TAG_MAX_W
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o      per-port handshake (N = 0, 1)
//   reqN_op_i, reqN_a_i, reqN_b_i    per-port op and operands
//   reqN_tag_i                       per-port caller tag
//   rsp_valid_o / rsp_ready_i        response handshake
//   rsp_result_o, rsp_id_o, rsp_tag_o  registered result, issuer, tag
//   busy_o                           response held or any request pending
module uriscv_alu_arb
  import uriscv_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [3:0]       req0_op_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [3:0]       req1_op_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,

  output logic             busy_o
);

  logic [1:0]  w_grant;
  logic        w_can_accept;
  logic        w_accept;
  alu_req_t    w_req0;
  alu_req_t    w_req1;
  alu_req_t    w_sel;
  logic [31:0] w_alu_result;
  logic        w_unused_tag;

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  alu_req_id_t      r_rsp_id;
  logic [TAG_W-1:0] r_rsp_tag;

  // The output register can take a new result when empty or being drained
  // this cycle; reset blocks acceptance so nothing is captured under reset.
  assign w_can_accept = !r_rsp_valid || rsp_ready_i;
  assign w_accept     = w_can_accept && (|w_grant) && !rst_i;

  assign req0_ready_o = w_can_accept && w_grant[0] && !rst_i;
  assign req1_ready_o = w_can_accept && w_grant[1] && !rst_i;

  uriscv_rr_arb2 u_arb (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_valid  ({req1_valid_i, req0_valid_i}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Pack each port into the shared bundle; tags are zero-extended.
  always_comb begin
    w_req0                  = '0;
    w_req0.op               = req0_op_i;
    w_req0.a                = req0_a_i;
    w_req0.b                = req0_b_i;
    w_req0.tag[TAG_W-1:0]   = req0_tag_i;

    w_req1                  = '0;
    w_req1.op               = req1_op_i;
    w_req1.a                = req1_a_i;
    w_req1.b                = req1_b_i;
    w_req1.tag[TAG_W-1:0]   = req1_tag_i;
  end

  always_comb begin
    w_sel = alu_req_idle();
    if (w_grant[0]) begin
      w_sel = w_req0;
    end else if (w_grant[1]) begin
      w_sel = w_req1;
    end
  end

  // Tag bits above TAG_W are always zero and never reach the output.
  assign w_unused_tag = ^w_sel.tag;

  uriscv_alu u_alu (
    .i_op     (w_sel.op),
    .i_a      (w_sel.a),
    .i_b      (w_sel.b),
    .o_result (w_alu_result)
  );

  // Response register: a new accept overrides a same-cycle consume, so a
  // streaming consumer sees back-to-back results with no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= REQ_PIPE;
      r_rsp_tag    <= '0;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_alu_result;
      r_rsp_id     <= w_grant[1] ? REQ_AUX : REQ_PIPE;
      r_rsp_tag    <= w_sel.tag[TAG_W-1:0];
    end else if (rsp_ready_i) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_rsp_result;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_tag_o    = r_rsp_tag;

  assign busy_o = r_rsp_valid || req0_valid_i || req1_valid_i;

endmodule

// File: tb/tb_uriscv_alu_arb.sv
// tb/tb_uriscv_alu_arb.sv - directed scoreboard bench for uriscv_alu_arb
module tb_uriscv_alu_arb;
  import uriscv_defs::*;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [3:0]       req0_op;
  logic [31:0]      req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [3:0]       req1_op;
  logic [31:0]      req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  uriscv_alu_arb #(.TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req0_tag_i   (req0_tag),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req1_tag_i   (req1_tag),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_id_o     (rsp_id),
    .rsp_tag_o    (rsp_tag),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic             id;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      RV_ALU_ADD:              return a + b;
      RV_ALU_SUB:              return a - b;
      RV_ALU_AND:              return a & b;
      RV_ALU_OR:               return a | b;
      RV_ALU_XOR:              return a ^ b;
      RV_ALU_SHIFTL:           return a << b[4:0];
      RV_ALU_SHIFTR:           return a >> b[4:0];
      RV_ALU_SHIFTR_ARITH:     return sa >>> b[4:0];
      RV_ALU_LESS_THAN:        return (a < b) ? 32'd1 : 32'd0;
      RV_ALU_LESS_THAN_SIGNED: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:                 return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Per-cycle scoreboard at the negedge: pop/compare a consumed response,
  // then push the expectation for any transfer accepted this cycle.
  task automatic sb();
    exp_t e;
    chk("ready_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      chk("sb_pending", {31'b0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
        chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, e.tag});
      end
    end
    if (req0_valid && req0_ready === 1'b1)
      q.push_back('{ref_alu(req0_op, req0_a, req0_b), 1'b0, req0_tag});
    if (req1_valid && req1_ready === 1'b1)
      q.push_back('{ref_alu(req1_op, req1_a, req1_b), 1'b1, req1_tag});
  endtask

  task automatic neg();
    @(negedge clk);
    sb();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_g;
    logic       r0, r1;
    logic [3:0] t0, t1;

    // Reset, with port 0 already requesting.
    rst = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b1, RV_ALU_ADD, 32'd100, 32'd1, 4'd1);
    set1(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    pos();
    pos();
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    chk("rst_rsp_tag", {28'b0, rsp_tag}, 32'd0);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);

    // Conflict for 4 cycles right after reset.
`ifdef URISCV_ALU_ARB_RR_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b0000;
`endif
    rst = 1'b0;
    t0 = 4'd1;
    t1 = 4'd8;
    set1(1'b1, RV_ALU_XOR, 32'hF0F0_0000, 32'h0000_0F0F, t1);
    for (int i = 0; i < 4; i++) begin
      neg();
      r0 = req0_ready;
      r1 = req1_ready;
      chk($sformatf("conflict%0d_ready0", i), {31'b0, r0}, {31'b0, !exp_g[i]});
      chk($sformatf("conflict%0d_ready1", i), {31'b0, r1}, {31'b0, exp_g[i]});
      pos();
      if (r0 === 1'b1) begin
        t0 = t0 + 4'd1;
        set0(1'b1, RV_ALU_ADD, 32'd100 + 32'(i), 32'd1, t0);
      end
      if (r1 === 1'b1) begin
        t1 = t1 + 4'd1;
        set1(1'b1, RV_ALU_XOR, 32'hF0F0_0000 + 32'(i), 32'h0000_0F0F, t1);
      end
    end
    set0(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    set1(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    neg();
    pos();

    // Single op on port 0.
    set0(1'b1, RV_ALU_ADD, 32'd5, 32'd7, 4'd3);
    neg();
    chk("single_ready0", {31'b0, req0_ready}, 32'd1);
    pos();
    set0(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    chk("single_valid", {31'b0, rsp_valid}, 32'd1);
    chk("single_result", rsp_result, 32'd12);
    chk("single_id", {31'b0, rsp_id}, 32'd0);
    chk("single_tag", {28'b0, rsp_tag}, 32'd3);
    neg();
    pos();
    chk("idle_valid", {31'b0, rsp_valid}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Backpressure with a conflict pending through the stall.
    set0(1'b1, RV_ALU_SUB, 32'd1, 32'd2, 4'd5);
    neg();
    pos();
    rsp_ready = 1'b0;
    set0(1'b1, RV_ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd6);
    set1(1'b1, RV_ALU_OR, 32'h0000_00F0, 32'h0000_000F, 4'd9);
    for (int i = 0; i < 3; i++) begin
      neg();
      chk($sformatf("stall%0d_ready0", i), {31'b0, req0_ready}, 32'd0);
      chk($sformatf("stall%0d_ready1", i), {31'b0, req1_ready}, 32'd0);
      chk($sformatf("stall%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_result", i), rsp_result, 32'hFFFF_FFFF);
      pos();
    end
    rsp_ready = 1'b1;
    neg();
`ifdef URISCV_ALU_ARB_RR_EN
    chk("release_ready0", {31'b0, req0_ready}, 32'd0);
    chk("release_ready1", {31'b0, req1_ready}, 32'd1);
    pos();
    chk("release_valid", {31'b0, rsp_valid}, 32'd1);
    set1(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    neg();
    chk("release2_ready0", {31'b0, req0_ready}, 32'd1);
`else
    chk("release_ready0", {31'b0, req0_ready}, 32'd1);
    chk("release_ready1", {31'b0, req1_ready}, 32'd0);
    pos();
    chk("release_valid", {31'b0, rsp_valid}, 32'd1);
    set0(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    neg();
    chk("release2_ready1", {31'b0, req1_ready}, 32'd1);
`endif
    pos();
    set0(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    set1(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    neg();
    pos();

    // Arithmetic shift through port 1.
    set1(1'b1, RV_ALU_SHIFTR_ARITH, 32'h8000_0000, 32'd4, 4'd7);
    neg();
    chk("shift_ready1", {31'b0, req1_ready}, 32'd1);
    pos();
    set1(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    chk("shift_result", rsp_result, 32'hF800_0000);
    chk("shift_id", {31'b0, rsp_id}, 32'd1);
    neg();
    pos();

    // Reset while a result is held and port 1 is requesting.
    set0(1'b1, RV_ALU_OR, 32'h12, 32'h21, 4'd2);
    neg();
    pos();
    set0(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    rsp_ready = 1'b0;
    set1(1'b1, RV_ALU_ADD, 32'd40, 32'd2, 4'd4);
    rst = 1'b1;
    neg();
    chk("midrst_ready1", {31'b0, req1_ready}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd1);
    pos();
    chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_result", rsp_result, 32'd0);
    q.delete();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, RV_ALU_SUB, 32'd50, 32'd8, 4'd1);
    neg();
    chk("postrst_ready0", {31'b0, req0_ready}, 32'd1);
    chk("postrst_ready1", {31'b0, req1_ready}, 32'd0);
    pos();
    set0(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    neg();
    chk("postrst2_ready1", {31'b0, req1_ready}, 32'd1);
    pos();
    set1(1'b0, RV_ALU_ADD, 32'd0, 32'd0, 4'd0);
    neg();
    pos();
    chk("sb_drained", q.size(), 32'd0);
    chk("end_valid", {31'b0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uriscv_alu_arb.md
# uriscv_alu_arb

Two-port arbiter that shares one `uriscv_alu` instance between two requesters: port 0 is the integer pipeline execute stage, port 1 is the address/CSR helper. Each port presents an op/operand pair with a valid/ready handshake. Each granted operation is computed in one cycle. The result is held in a single output register with its own valid/ready handshake, tagged with the requester id and a caller tag.

## Interface
Parameters:
- `TAG_W`, default 4: width of the caller tag carried with each operation.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req0_valid_i`  in  1  port 0 has an operation.
- `req0_ready_o`  out  1  port 0 operation accepted this cycle.
- `req0_op_i`  in  4  port 0 ALU op, `RV_ALU_*` encoding.
- `req0_a_i`, `req0_b_i`  in  32  port 0 operands.
- `req0_tag_i`  in  TAG_W  port 0 caller tag.
- `req1_valid_i`, `req1_ready_o`, `req1_op_i`, `req1_a_i`, `req1_b_i`, `req1_tag_i`: same as port 0, for port 1.
- `rsp_valid_o`  out  1  result register holds a result.
- `rsp_ready_i`  in  1  consumer takes the result.
- `rsp_result_o`  out  32  ALU result.
- `rsp_id_o`  out  1  requester that issued the operation (0 or 1).
- `rsp_tag_o`  out  TAG_W  tag of the issuing operation.
- `busy_o`  out  1  `rsp_valid_o` is set, or either `reqN_valid_i` is set.

## Operation
- `can_accept = !rsp_valid_o || rsp_ready_i`.
- Grant is computed combinationally from both valids and the priority state. At most one port is granted per cycle.
- `reqN_ready_o = can_accept && grantN`.
  - Ready may depend on valid.
  - A requester must hold valid, op, operands and tag stable until ready.
- Mux the granted port's op, a and b into the shared ALU.
  - When nothing is granted, drive op = `RV_ALU_ADD` with a = b = 0, so there is no X propagation.
- On an accepted transfer, register:
  - ALU output into `rsp_result_o`
  - granted index into `rsp_id_o`
  - granted tag into `rsp_tag_o`
  - set `rsp_valid_o`.
- On `rsp_valid_o && rsp_ready_i` with no new transfer, clear `rsp_valid_o`. Data fields keep their last value.
- Simultaneous consume and accept: the new result replaces the old one and `rsp_valid_o` stays 1. The consumer saw the old result in the same cycle.
- Only one valid port: it is granted, regardless of priority state.
- Both ports valid: see Configuration.
- The priority state `last_grant` (1 bit) updates only on an accepted transfer, never on grant alone while stalled.
- Reset mid-operation: any result in flight is discarded. A requester held valid through reset is accepted normally once reset deasserts.

## Timing
- Latency: accepted in cycle N, result on `rsp_*` in cycle N+1.
- Throughput: 1 operation per cycle while `rsp_ready_i` = 1.
- Backpressure: `rsp_valid_o` = 1 and `rsp_ready_i` = 0 drives both `reqN_ready_o` to 0 in the same cycle. Only the output register holds operations; there is no internal queue.
- Values while `rst_i` is high, and in the cycle after:
  - `rsp_valid_o` = 0
  - `rsp_result_o` = 0
  - `rsp_id_o` = 0
  - `rsp_tag_o` = 0
  - `last_grant` = 1, so port 0 wins the first conflict
  - `reqN_ready_o` = 0 while `rst_i` is high
  - `busy_o` follows its equation.
- All outputs except `reqN_ready_o` and `busy_o` are registered.

## Configuration
- Macro: `URISCV_ALU_ARB_RR_EN`.
- Defined (round-robin): on conflict, grant the port that is not `last_grant`. Each port is guaranteed service within 2 accepted transfers.
- Undefined (fixed priority): port 0 always wins conflicts and `last_grant` is unused. Port 1 can starve; this is acceptable for single-issue use.

## Structure
- ALU op encodings stay in `uriscv_defs.sv`.
- Shared package `uriscv_pkg` holds:
  - `typedef enum logic {REQ_PIPE = 1'b0, REQ_AUX = 1'b1} alu_req_id_t`
  - a packed struct `alu_req_t {op, a, b, tag}` used for the port mux.
- Sub-module `uriscv_rr_arb2`: a 2-way arbiter.
  - Inputs: valids, `last_grant`, and an accept strobe.
  - Outputs: one-hot grant.
  - Contains the `URISCV_ALU_ARB_RR_EN` switch and the `last_grant` register.
- The top level instantiates `uriscv_rr_arb2` and `uriscv_alu`, and holds the response register.

## Test plan
- Single op: port 0 valid, op `RV_ALU_ADD`, a = 5, b = 7, tag = 3, `rsp_ready_i` = 1.
  - Expect `req0_ready_o` = 1 in cycle N.
  - Expect result 12, `rsp_id_o` = 0, `rsp_tag_o` = 3 in cycle N+1.
- Conflict, `URISCV_ALU_ARB_RR_EN` defined: both ports valid for 4 cycles with distinct tags, `rsp_ready_i` = 1.
  - Expect grants 0, 1, 0, 1.
  - Without the macro: expect 0, 0, 0, 0.
- Backpressure: hold `rsp_ready_i` = 0 for 3 cycles after one result (`RV_ALU_SUB`, a = 1, b = 2 gives `32'hFFFF_FFFF`).
  - Expect both readies 0 and the result stable.
  - Release: next op accepted in the same cycle as the consume, with no bubble.
- Round-robin state under stall: conflict while stalled for 2 cycles.
  - Expect `last_grant` unchanged and the same port granted on release.
- Shift through port 1: `RV_ALU_SHIFTR_ARITH`, a = `32'h8000_0000`, b = 4.
  - Expect `32'hF800_0000` with `rsp_id_o` = 1.
- Reset mid-stream: assert `rst_i` while `rsp_valid_o` = 1 and port 1 is valid.
  - Expect `rsp_valid_o` = 0 the next cycle.
  - After deassert, the first conflict is granted to port 0.
